// File: rtl/rggen_initiator_pkg.sv
// Shared encodings for the register initiator: access types, response status
// codes and FSM states.
package rggen_initiator_pkg;

  localparam logic [1:0] ACCESS_READ        = 2'b10;
  localparam logic [1:0] ACCESS_WRITE       = 2'b11;
  localparam logic [1:0] STATUS_OKAY        = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } state_e;

  // Number of byte-offset address bits covered by one bus word.
  function automatic int unsigned byte_lsb(input int unsigned bus_width);
    return $clog2(bus_width / 8);
  endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// Bitwise OR of status and read data across the responders selected by i_hit.
module rggen_or_reducer #(
  parameter int BUS_WIDTH = 32,
  parameter int REGISTERS = 1
) (
  input  logic [REGISTERS-1:0]           i_hit,
  input  logic [2*REGISTERS-1:0]         i_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
  output logic [1:0]                     o_status,
  output logic [BUS_WIDTH-1:0]           o_read_data
);

  always_comb begin
    o_status    = '0;
    o_read_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_hit[i]) begin
        o_status    = o_status | i_status[2*i+:2];
        o_read_data = o_read_data | i_read_data[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_register_initiator.sv
// Command-to-register-bus initiator: captures one command, drives it onto the
// register bus until a responder answers (or times out), then returns a response.
module rggen_register_initiator
  import rggen_initiator_pkg::*;
#(
  parameter int   ADDRESS_WIDTH  = 8,
  parameter int   BUS_WIDTH      = 32,
  parameter int   REGISTERS      = 1,
  parameter int   TIMEOUT_CYCLES = 16,
  parameter logic ERROR_STATUS   = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic                           i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]       i_cmd_address,
  input  logic [BUS_WIDTH-1:0]           i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_cmd_strobe,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [1:0]                     o_rsp_status,
  output logic [BUS_WIDTH-1:0]           o_rsp_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    {ADDRESS_WIDTH{1'b1}} << byte_lsb(BUS_WIDTH);
  localparam logic [15:0] TIMEOUT_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  UNMAPPED_STATUS = ERROR_STATUS ? STATUS_SLAVE_ERROR : STATUS_OKAY;

  state_e                    r_state;
  logic                      r_cmd_ready;
  logic                      r_rsp_valid;
  logic [1:0]                r_rsp_status;
  logic [BUS_WIDTH-1:0]      r_rsp_read_data;
  logic                      r_register_valid;
  logic [1:0]                r_register_access;
  logic [ADDRESS_WIDTH-1:0]  r_register_address;
  logic [BUS_WIDTH-1:0]      r_register_write_data;
  logic [STROBE_WIDTH-1:0]   r_register_strobe;
  logic [15:0]               r_wait_count;

  logic [REGISTERS-1:0]      w_hit;
  logic [1:0]                w_hit_status;
  logic [BUS_WIDTH-1:0]      w_hit_read_data;
  logic                      w_any_active;
  logic                      w_timeout;

  assign w_hit        = i_register_active & i_register_ready;
  assign w_any_active = |i_register_active;
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_wait_count == TIMEOUT_LAST);

  rggen_or_reducer #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_or_reducer (
    .i_hit       (w_hit),
    .i_status    (i_register_status),
    .i_read_data (i_register_read_data),
    .o_status    (w_hit_status),
    .o_read_data (w_hit_read_data)
  );

  // o_cmd_ready is registered, so it rises on the first edge after reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state               <= IDLE;
      r_cmd_ready           <= 1'b0;
      r_rsp_valid           <= 1'b0;
      r_rsp_status          <= '0;
      r_rsp_read_data       <= '0;
      r_register_valid      <= 1'b0;
      r_register_access     <= '0;
      r_register_address    <= '0;
      r_register_write_data <= '0;
      r_register_strobe     <= '0;
      r_wait_count          <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready           <= 1'b0;
            r_register_valid      <= 1'b1;
            r_register_access     <= i_cmd_write ? ACCESS_WRITE : ACCESS_READ;
            r_register_address    <= i_cmd_address & ADDRESS_MASK;
            r_register_write_data <= i_cmd_write_data;
            r_register_strobe     <= i_cmd_write ? i_cmd_strobe : '1;
            r_wait_count          <= '0;
            r_state               <= ACCESS;
          end
        end
        ACCESS: begin
          if (|w_hit) begin
            r_rsp_status     <= w_hit_status;
            r_rsp_read_data  <= w_hit_read_data;
            r_rsp_valid      <= 1'b1;
            r_register_valid <= 1'b0;
            r_state          <= RESPOND;
          end else if (!w_any_active) begin
            r_rsp_status     <= UNMAPPED_STATUS;
            r_rsp_read_data  <= '0;
            r_rsp_valid      <= 1'b1;
            r_register_valid <= 1'b0;
            r_state          <= RESPOND;
          end else if (w_timeout) begin
            r_rsp_status     <= STATUS_SLAVE_ERROR;
            r_rsp_read_data  <= '0;
            r_rsp_valid      <= 1'b1;
            r_register_valid <= 1'b0;
            r_state          <= RESPOND;
          end else begin
            r_wait_count <= r_wait_count + 16'd1;
          end
        end
        RESPOND: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready           = r_cmd_ready;
  assign o_rsp_valid           = r_rsp_valid;
  assign o_rsp_status          = r_rsp_status;
  assign o_rsp_read_data       = r_rsp_read_data;
  assign o_register_valid      = r_register_valid;
  assign o_register_access     = r_register_access;
  assign o_register_address    = r_register_address;
  assign o_register_write_data = r_register_write_data;
  assign o_register_strobe     = r_register_strobe;

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Scoreboard bench: two initiators (ERROR_STATUS 1 and 0) share all inputs and
// are checked against a transaction-level model of the responder handshake.
module tb_rggen_register_initiator;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 3;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_valid   = 1'b0;
  logic           cmd_write   = 1'b0;
  logic [AW-1:0]  cmd_address = '0;
  logic [BW-1:0]  cmd_wdata   = '0;
  logic [3:0]     cmd_strobe  = '0;
  logic           rsp_ready   = 1'b0;
  logic [NR-1:0]  reg_active  = '0;
  logic [NR-1:0]  reg_ready   = '0;
  logic [2*NR-1:0]  reg_status = '0;
  logic [BW*NR-1:0] reg_rdata  = '0;

  logic          cmd_ready   [2];
  logic          rsp_valid   [2];
  logic [1:0]    rsp_status  [2];
  logic [BW-1:0] rsp_data    [2];
  logic          reg_valid   [2];
  logic [1:0]    reg_access  [2];
  logic [AW-1:0] reg_address [2];
  logic [BW-1:0] reg_wdata   [2];
  logic [3:0]    reg_strobe  [2];

  rggen_register_initiator #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR),
    .TIMEOUT_CYCLES(TO), .ERROR_STATUS(1'b1)
  ) dut_err (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[0]),
    .i_cmd_write(cmd_write), .i_cmd_address(cmd_address),
    .i_cmd_write_data(cmd_wdata), .i_cmd_strobe(cmd_strobe),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready),
    .o_rsp_status(rsp_status[0]), .o_rsp_read_data(rsp_data[0]),
    .o_register_valid(reg_valid[0]), .o_register_access(reg_access[0]),
    .o_register_address(reg_address[0]), .o_register_write_data(reg_wdata[0]),
    .o_register_strobe(reg_strobe[0]),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  rggen_register_initiator #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR),
    .TIMEOUT_CYCLES(TO), .ERROR_STATUS(1'b0)
  ) dut_okay (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready[1]),
    .i_cmd_write(cmd_write), .i_cmd_address(cmd_address),
    .i_cmd_write_data(cmd_wdata), .i_cmd_strobe(cmd_strobe),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready),
    .o_rsp_status(rsp_status[1]), .o_rsp_read_data(rsp_data[1]),
    .o_register_valid(reg_valid[1]), .o_register_access(reg_access[1]),
    .o_register_address(reg_address[1]), .o_register_write_data(reg_wdata[1]),
    .o_register_strobe(reg_strobe[1]),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_rdata)
  );

  typedef struct {
    logic [1:0]  status;
    logic [31:0] data;
    int          lat;
    int          accept;
    int          rsp_delay;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_accept = 0;

  logic        cfg_write = 1'b0;
  logic [7:0]  cfg_addr  = '0;
  logic [31:0] cfg_wdata = '0;
  logic [3:0]  cfg_strb  = '0;
  logic [2:0]  cfg_active = '0;
  int          cfg_delay [NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register responders: an active responder raises ready once the access has
  // lasted its configured delay; inactive ones toggle ready at random.
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (reg_valid[0]) begin
      for (int k = 0; k < NR; k++)
        reg_ready[k] = cfg_active[k] ? (acc_cnt >= cfg_delay[k]) : 1'($urandom);
      if (acc_cnt == 0) begin
        chk("reg_access", reg_access[0], cfg_write ? 2'b11 : 2'b10);
        chk("reg_address", reg_address[0], cfg_addr & 8'hFC);
        chk("reg_strobe", reg_strobe[0], cfg_write ? cfg_strb : 4'hF);
        if (cfg_write) chk("reg_wdata", reg_wdata[0], cfg_wdata);
        chk("cmd_ready_in_access", cmd_ready[0], 0);
        chk("reg_valid_pair", reg_valid[1], 1);
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      reg_ready = 3'($urandom);
    end
  end

  // Response monitor and sink.
  logic        in_rsp = 1'b0;
  int          hold_cnt = 0;
  int          cur_delay = 0;
  logic [1:0]  held_s;
  logic [31:0] held_d;
  exp_t        m0, m1;
  always @(negedge clk) begin
    if (rst) begin
      in_rsp    = 1'b0;
      rsp_ready = 1'b0;
    end else if (rsp_valid[0] || rsp_valid[1]) begin
      if (!in_rsp) begin
        in_rsp   = 1'b1;
        hold_cnt = 0;
        if (q0.size() == 0 || q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: response status=%0h with no command outstanding", rsp_status[0]);
          cur_delay = 0;
        end else begin
          m0 = q0.pop_front();
          m1 = q1.pop_front();
          chk("rsp_status_err", rsp_status[0], m0.status);
          chk("rsp_data_err", rsp_data[0], m0.data);
          chk("rsp_status_okay", rsp_status[1], m1.status);
          chk("rsp_data_okay", rsp_data[1], m1.data);
          chk("rsp_latency", cyc - m0.accept, m0.lat);
          chk("rsp_valid_pair", rsp_valid[1], rsp_valid[0]);
          cur_delay = m0.rsp_delay;
        end
        held_s = rsp_status[0];
        held_d = rsp_data[0];
      end else begin
        hold_cnt++;
        chk("rsp_hold_status", rsp_status[0], held_s);
        chk("rsp_hold_data", rsp_data[0], held_d);
        chk("cmd_ready_in_rsp", cmd_ready[0], 0);
      end
      rsp_ready = (hold_cnt >= cur_delay);
    end else begin
      in_rsp    = 1'b0;
      rsp_ready = 1'b0;
    end
  end

  task automatic wait_cmd_ready();
    int guard = 0;
    while (!cmd_ready[0] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", cmd_ready[0], 1);
  endtask

  // Issues one command; the expected response is derived from the responder
  // configuration: earliest ready among active responders wins unless it
  // comes later than the timeout window.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [2:0] act,
                       input int d0, input int d1, input int d2,
                       input logic [5:0] st, input logic [95:0] rd, input int rdly);
    exp_t e0, e1;
    int first;
    logic [1:0] s;
    logic [31:0] d;
    wait_cmd_ready();
    cfg_write = w; cfg_addr = a; cfg_wdata = wd; cfg_strb = sb; cfg_active = act;
    cfg_delay[0] = d0; cfg_delay[1] = d1; cfg_delay[2] = d2;
    reg_active = act; reg_status = st; reg_rdata = rd;
    first = NEVER;
    for (int k = 0; k < NR; k++)
      if (act[k] && cfg_delay[k] < first) first = cfg_delay[k];
    if (act == 3'b000) begin
      e0.status = 2'b10; e1.status = 2'b00; e0.data = '0; e0.lat = 1;
    end else if (first < TO) begin
      s = '0; d = '0;
      for (int k = 0; k < NR; k++)
        if (act[k] && cfg_delay[k] <= first) begin
          s = s | st[2*k+:2];
          d = d | rd[32*k+:32];
        end
      e0.status = s; e1.status = s; e0.data = d; e0.lat = first + 1;
    end else begin
      e0.status = 2'b10; e1.status = 2'b10; e0.data = '0; e0.lat = TO;
    end
    e0.rsp_delay = rdly;
    cmd_write = w; cmd_address = a; cmd_wdata = wd; cmd_strobe = sb; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid   = 1'b0;
    last_accept = cyc;
    e0.accept   = cyc;
    e1.data = e0.data; e1.lat = e0.lat; e1.accept = e0.accept; e1.rsp_delay = e0.rsp_delay;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  initial begin
    int t1;
    int guard;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready[0], 0);
    chk("rst_rsp_valid", rsp_valid[0], 0);
    chk("rst_reg_valid", reg_valid[0], 0);
    chk("rst_reg_fields", {reg_access[0], reg_address[0], reg_strobe[0], reg_wdata[0]}, 0);
    chk("rst_rsp_fields", {rsp_status[0], rsp_data[0]}, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready[0], 1);

    issue(0, 8'h04, 32'h0, 4'h0, 3'b010, NEVER, 0, NEVER, 6'b11_00_11,
          {32'hDEAD0002, 32'hCAFE0001, 32'hDEAD0000}, 0);
    issue(1, 8'h08, 32'h12345678, 4'b0011, 3'b001, 0, NEVER, NEVER, 6'b00_00_00, 96'h0, 0);
    issue(0, 8'h08, 32'h0, 4'b0011, 3'b001, 0, NEVER, NEVER, 6'b00_00_00,
          {64'h0, 32'h12345678}, 0);
    issue(1, 8'h0B, 32'hA5A5A5A5, 4'b0000, 3'b001, 0, NEVER, NEVER, 6'b00_00_00, 96'h0, 0);
    issue(0, 8'h40, 32'h0, 4'hF, 3'b000, 0, 0, 0, 6'b11_11_11, {3{32'hFFFFFFFF}}, 0);
    issue(0, 8'h10, 32'h0, 4'hF, 3'b100, NEVER, NEVER, NEVER, 6'b00_00_00,
          {32'h11111111, 64'h0}, 0);
    issue(0, 8'h14, 32'h0, 4'hF, 3'b100, NEVER, NEVER, 15, 6'b00_11_11,
          {32'h0000BEEF, 32'h1, 32'h2}, 0);
    issue(0, 8'h18, 32'h0, 4'hF, 3'b011, 2, 2, NEVER, 6'b11_10_01,
          {32'hFFFFFFFF, 32'h00000F0F, 32'hF0F00000}, 5);
    issue(0, 8'h1C, 32'h0, 4'hF, 3'b001, 0, NEVER, NEVER, 6'b00_00_00, {64'h0, 32'h7}, 0);
    t1 = last_accept;
    issue(1, 8'h20, 32'h55, 4'h1, 3'b010, NEVER, 0, NEVER, 6'b00_00_00, 96'h0, 0);
    chk("throughput", last_accept - t1, 3);

    // Reset while the access is still waiting for ready.
    wait_cmd_ready();
    cfg_write = 1'b0; cfg_addr = 8'h24; cfg_strb = 4'hF; cfg_active = 3'b001;
    cfg_delay[0] = NEVER; cfg_delay[1] = NEVER; cfg_delay[2] = NEVER;
    reg_active = 3'b001;
    cmd_write = 1'b0; cmd_address = 8'h24; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reg_valid_before_rst", reg_valid[0], 1);
    #2 rst = 1'b1;
    #1 chk("reg_valid_async_drop", reg_valid[0], 0);
    chk("cmd_ready_in_rst", cmd_ready[0], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_rsp_after_rst", rsp_valid[0], 0);
    issue(0, 8'h2C, 32'h0, 4'hF, 3'b100, NEVER, NEVER, 1, 6'b01_00_00,
          {32'h600DF00D, 64'h0}, 1);

    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 8'($urandom), $urandom, 4'($urandom), 3'($urandom),
            int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
            int'($urandom_range(0, 20)), 6'($urandom),
            {$urandom, $urandom, $urandom}, int'($urandom_range(0, 3)));

    guard = 0;
    while ((q0.size() != 0 || in_rsp) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rggen_register_initiator.md
RGGEN_REGISTER_INITIATOR -- requirements
Module: rggen_register_initiator

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8, SHALL set the byte address width of the command and register buses.
REQ-002 Parameter BUS_WIDTH, default 32, SHALL set the data width; it SHALL be a multiple of 8.
REQ-003 Parameter REGISTERS, default 1, SHALL set the number of attached register responders.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum wait for ready in the ACCESS state; 0 SHALL disable the timeout.
REQ-005 Parameter ERROR_STATUS, default 1'b1, SHALL select a SLAVE_ERROR (1) or OKAY (0) response for unmatched addresses.
REQ-006 Reset: one clock; the reset is asynchronous and active-high; ports i_clk and i_rst.
REQ-007 Ports (name, direction, width, meaning):
- i_clk, in, 1: clock.
- i_rst, in, 1: asynchronous active-high reset.
- i_cmd_valid, in, 1: command request.
- o_cmd_ready, out, 1: command accepted.
- i_cmd_write, in, 1: 1 = write, 0 = read.
- i_cmd_address, in, ADDRESS_WIDTH: byte address.
- i_cmd_write_data, in, BUS_WIDTH: write data.
- i_cmd_strobe, in, BUS_WIDTH/8: byte strobes.
- o_rsp_valid, out, 1: response valid.
- i_rsp_ready, in, 1: response accepted.
- o_rsp_status, out, 2: response status.
- o_rsp_read_data, out, BUS_WIDTH: read data.
- o_register_valid, out, 1: register bus request.
- o_register_access, out, 2: register access type.
- o_register_address, out, ADDRESS_WIDTH: register address.
- o_register_write_data, out, BUS_WIDTH: register write data.
- o_register_strobe, out, BUS_WIDTH/8: register byte strobes.
- i_register_active, in, REGISTERS: per-register address match.
- i_register_ready, in, REGISTERS: per-register ready.
- i_register_status, in, 2*REGISTERS: per-register status, packed.
- i_register_read_data, in, BUS_WIDTH*REGISTERS: per-register read data, packed.

Function
REQ-008 The FSM SHALL have three states: IDLE, ACCESS and RESPOND.
REQ-009 In IDLE, o_cmd_ready SHALL be 1; when i_cmd_valid=1, the block SHALL capture the command and enter ACCESS on the next edge.
REQ-010 The captured address SHALL have its low log2(BUS_WIDTH/8) bits forced to 0.
REQ-011 On a read, the captured strobe SHALL be all ones.
REQ-012 In ACCESS, o_register_valid SHALL be 1 and the captured fields SHALL be driven.
REQ-013 o_register_access SHALL be ACCESS_WRITE or ACCESS_READ according to the command.
REQ-014 In ACCESS, hit = i_register_active & i_register_ready.
REQ-015 If any hit bit is 1, the block SHALL register status and data and enter RESPOND.
REQ-016 On a hit, status and data SHALL be the bitwise OR over responders masked by hit.
REQ-017 If no i_register_active bit is 1, the block SHALL enter RESPOND with status SLAVE_ERROR (ERROR_STATUS=1) or OKAY (ERROR_STATUS=0), and data 0.
REQ-018 A 16-bit-max wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without a hit.
REQ-019 When the counter reaches TIMEOUT_CYCLES-1 without a hit (TIMEOUT_CYCLES>0), the block SHALL enter RESPOND with SLAVE_ERROR and data 0.
REQ-020 If a hit occurs in the timeout cycle, the hit SHALL take precedence.
REQ-021 In RESPOND, o_rsp_valid SHALL be 1 and status and data SHALL be held stable until i_rsp_ready=1; the block SHALL then return to IDLE.
REQ-022 Outside ACCESS, o_register_valid SHALL be 0; outside IDLE, o_cmd_ready SHALL be 0.
REQ-023 Minimum latency SHALL be 3 cycles from cmd accept to rsp handshake; maximum throughput SHALL be one command per 3 cycles.
REQ-024 A write with an all-zero strobe SHALL still be issued on the register bus.

Reset
REQ-025 While i_rst=1, the state SHALL be IDLE and all outputs SHALL be 0 except o_cmd_ready, which SHALL be 1 after release.
REQ-026 A reset asserted in ACCESS or RESPOND SHALL abandon the transaction with no response.

Structure
REQ-027 Package rggen_initiator_pkg SHALL hold ACCESS_READ=2'b10, ACCESS_WRITE=2'b11, STATUS_OKAY=2'b00 and STATUS_SLAVE_ERROR=2'b10.
REQ-028 The package SHALL also hold the state encoding IDLE=2'b00, ACCESS=2'b01 and RESPOND=2'b10.
REQ-029 One sub-module, rggen_or_reducer, SHALL perform the masked status and data reduction.

Verification
REQ-030 Read 0x04: register 1 active and ready in the 1st ACCESS cycle with data 0xCAFE0001 -> rsp data 0xCAFE0001, status OKAY, rsp_valid on cycle 3.
REQ-031 Write 0x08 with data 0x12345678 and strobe 4'b0011 -> register bus shows ACCESS_WRITE, address 0x08, strobe 4'b0011; read of 0x08 -> strobe 4'hF.
REQ-032 Address 0x40 with no active register, ERROR_STATUS=1 -> status SLAVE_ERROR, data 0; with ERROR_STATUS=0 -> status OKAY.
REQ-033 Active but ready=0 for 20 cycles, TIMEOUT_CYCLES=16 -> SLAVE_ERROR after exactly 16 ACCESS cycles; ready at cycle 16 -> OKAY.
REQ-034 Hold i_rsp_ready=0 for 5 cycles -> response held stable and o_cmd_ready=0 throughout.
REQ-035 Pulse i_rst in ACCESS -> o_register_valid drops asynchronously, no response follows, and the next command completes normally.
